// File: rtl/pipe_reg_em_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : em_pkg
// Brief    : Shared types and helpers for the Execute->Memory stage register.
// Revision : 1.0
// ============================================================================
package em_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int WA_W_DEF   = 4;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } em_ctrl_t;

  typedef struct packed {
    em_ctrl_t                ctrl;
    logic [DATA_W_DEF-1:0]   alu_result;
    logic [DATA_W_DEF-1:0]   write_data;
    logic [WA_W_DEF-1:0]     wa3;
  } em_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } em_state_t;

  // Control bits must never leak out of an empty stage.
  function automatic em_ctrl_t gate_ctrl(input em_ctrl_t c, input logic v);
    return c & {$bits(em_ctrl_t){v}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_em_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_em_hs_if
// Brief    : Handshake, payload and counter bundle around the E->M register.
// Revision : 1.0
// ============================================================================
interface pipe_reg_em_hs_if #(
  parameter int DATA_W = 32,
  parameter int WA_W   = 4,
  parameter int CNT_W  = 16
);
  logic              ValidE;
  logic              ReadyE;
  logic              FlushE;
  logic              PCSrcE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic [DATA_W-1:0] ALUResultE;
  logic [DATA_W-1:0] WriteDataE;
  logic [WA_W-1:0]   WA3E;
  logic              ValidM;
  logic              ReadyM;
  logic              PCSrcM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [WA_W-1:0]   WA3M;
  logic              CntClr;
  logic [CNT_W-1:0]  StallCnt;
  logic [CNT_W-1:0]  BubbleCnt;

  modport master (
    output ValidE, FlushE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE,
           ALUResultE, WriteDataE, WA3E, ReadyM, CntClr,
    input  ReadyE, ValidM, PCSrcM, RegWriteM, MemtoRegM, MemWriteM,
           ALUResultM, WriteDataM, WA3M, StallCnt, BubbleCnt
  );

  modport slave (
    input  ValidE, FlushE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE,
           ALUResultE, WriteDataE, WA3E, ReadyM, CntClr,
    output ReadyE, ValidM, PCSrcM, RegWriteM, MemtoRegM, MemWriteM,
           ALUResultM, WriteDataM, WA3M, StallCnt, BubbleCnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_em_hs_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear taking priority.
// Revision : 1.0
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (clr)
      r_count <= '0;
    else if (inc && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/pipe_reg_em_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_em_hs
// Brief    : Execute->Memory stage register, valid/ready, flush, optional skid.
// Revision : 1.0
// ============================================================================
module pipe_reg_em_hs
  import em_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WA_W   = 4,
  parameter int CNT_W  = 16,
  parameter int SKID   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  pipe_reg_em_hs_if.slave  bus
);
  em_state_t         r_state, w_next;
  em_ctrl_t          r_main_ctrl, r_skid_ctrl, w_in_ctrl, w_out_ctrl;
  logic [DATA_W-1:0] r_main_alu, r_main_wd, r_skid_alu, r_skid_wd;
  logic [WA_W-1:0]   r_main_wa, r_skid_wa;
  logic              w_ready, w_valid, w_in, w_out;
  logic              w_ld_in, w_ld_skid, w_skid_to_main;
  logic              w_stall_inc, w_bubble_inc;

  assign w_valid   = (r_state != EMPTY);
  assign w_in      = bus.ValidE & w_ready;
  assign w_out     = w_valid & bus.ReadyM;
  assign w_in_ctrl = '{pcsrc: bus.PCSrcE, regwrite: bus.RegWriteE,
                       memtoreg: bus.MemtoRegE, memwrite: bus.MemWriteE};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_ld_in        = 1'b0;
    w_ld_skid      = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      EMPTY: if (w_in) begin w_next = ONE; w_ld_in = 1'b1; end
      ONE: begin
        if (w_in && w_out)              w_ld_in = 1'b1;
        else if (w_in && (SKID != 0)) begin w_next = FULL; w_ld_skid = 1'b1; end
        else if (w_out)                 w_next = EMPTY;
      end
      FULL: if (w_out) begin w_next = ONE; w_skid_to_main = 1'b1; end
      default: w_next = EMPTY;
    endcase
    // Flush drops any concurrent IN; a concurrent OUT is already owned downstream.
    if (bus.FlushE) begin
      w_next         = EMPTY;
      w_ld_in        = 1'b0;
      w_ld_skid      = 1'b0;
      w_skid_to_main = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_main_ctrl <= '0; r_main_alu <= '0; r_main_wd <= '0; r_main_wa <= '0;
      r_skid_ctrl <= '0; r_skid_alu <= '0; r_skid_wd <= '0; r_skid_wa <= '0;
    end else begin
      if (w_ld_in) begin
        r_main_ctrl <= w_in_ctrl;       r_main_alu <= bus.ALUResultE;
        r_main_wd   <= bus.WriteDataE;  r_main_wa  <= bus.WA3E;
      end else if (w_skid_to_main) begin
        r_main_ctrl <= r_skid_ctrl;     r_main_alu <= r_skid_alu;
        r_main_wd   <= r_skid_wd;       r_main_wa  <= r_skid_wa;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= w_in_ctrl;       r_skid_alu <= bus.ALUResultE;
        r_skid_wd   <= bus.WriteDataE;  r_skid_wa  <= bus.WA3E;
      end
    end
  end

  if (SKID != 0) begin : g_skid_ready
    logic r_ready;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_ready <= 1'b1;
      else     r_ready <= (w_next != FULL);
    end
    assign w_ready = r_ready;
  end else begin : g_comb_ready
    assign w_ready = ~w_valid | bus.ReadyM;
  end

  assign w_out_ctrl     = gate_ctrl(r_main_ctrl, w_valid);
  assign bus.ReadyE     = w_ready;
  assign bus.ValidM     = w_valid;
  assign bus.PCSrcM     = w_out_ctrl.pcsrc;
  assign bus.RegWriteM  = w_out_ctrl.regwrite;
  assign bus.MemtoRegM  = w_out_ctrl.memtoreg;
  assign bus.MemWriteM  = w_out_ctrl.memwrite;
  assign bus.ALUResultM = r_main_alu;
  assign bus.WriteDataM = r_main_wd;
  assign bus.WA3M       = r_main_wa;

  assign w_stall_inc  = w_valid & ~bus.ReadyM;
  assign w_bubble_inc = ~w_valid & bus.ReadyM;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(CLK), .rst(RST), .inc(w_stall_inc), .clr(bus.CntClr), .count(bus.StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(CLK), .rst(RST), .inc(w_bubble_inc), .clr(bus.CntClr), .count(bus.BubbleCnt)
  );
endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_em_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_reg_em_hs
// Brief    : Directed bench: skid instance (CNT_W=4) and combinational-ready instance.
// Revision : 1.0
// ============================================================================
module tb_pipe_reg_em_hs;
  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  pipe_reg_em_hs_if #(.DATA_W(32), .WA_W(4), .CNT_W(4))  ifa ();
  pipe_reg_em_hs_if #(.DATA_W(32), .WA_W(4), .CNT_W(16)) ifb ();

  pipe_reg_em_hs #(.DATA_W(32), .WA_W(4), .CNT_W(4), .SKID(1)) u_dut_a (
    .CLK(CLK), .RST(RST), .bus(ifa)
  );

  pipe_reg_em_hs #(.DATA_W(32), .WA_W(4), .CNT_W(16), .SKID(0)) u_dut_b (
    .CLK(CLK), .RST(RST), .bus(ifb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_a();
    ifa.ValidE = 0; ifa.FlushE = 0; ifa.PCSrcE = 0; ifa.RegWriteE = 0;
    ifa.MemtoRegE = 0; ifa.MemWriteE = 0; ifa.ALUResultE = '0;
    ifa.WriteDataE = '0; ifa.WA3E = '0; ifa.ReadyM = 0; ifa.CntClr = 0;
  endtask

  task automatic idle_b();
    ifb.ValidE = 0; ifb.FlushE = 0; ifb.PCSrcE = 0; ifb.RegWriteE = 0;
    ifb.MemtoRegE = 0; ifb.MemWriteE = 0; ifb.ALUResultE = '0;
    ifb.WriteDataE = '0; ifb.WA3E = '0; ifb.ReadyM = 0; ifb.CntClr = 0;
  endtask

  logic [31:0] stream_vals [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    stream_vals = '{32'h11, 32'h22, 32'h33};
    idle_a();
    idle_b();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1 RST = 0;

    check_val("rst_readyE_a", 32'(ifa.ReadyE), 32'd1);
    check_val("rst_validM_a", 32'(ifa.ValidM), 32'd0);
    check_val("rst_stall_a",  32'(ifa.StallCnt), 32'd0);
    check_val("rst_bubble_a", 32'(ifa.BubbleCnt), 32'd0);
    check_val("rst_alu_a",    ifa.ALUResultM, 32'd0);
    check_val("rst_readyE_b", 32'(ifb.ReadyE), 32'd1);

    // Streaming with ReadyM=1
    ifa.ReadyM = 1; ifa.ValidE = 1; ifa.RegWriteE = 1;
    for (int i = 0; i < 3; i++) begin
      ifa.ALUResultE = stream_vals[i];
      ifa.WA3E = 4'(i + 1);
      tick();
      check_val("stream_alu",    ifa.ALUResultM, stream_vals[i]);
      check_val("stream_wa3",    32'(ifa.WA3M), 32'(i + 1));
      check_val("stream_regwr",  32'(ifa.RegWriteM), 32'd1);
      check_val("stream_readyE", 32'(ifa.ReadyE), 32'd1);
    end
    ifa.ValidE = 0;
    tick();
    check_val("drain_validM", 32'(ifa.ValidM), 32'd0);
    check_val("drain_regwr_gated", 32'(ifa.RegWriteM), 32'd0);
    check_val("drain_alu_hold", ifa.ALUResultM, 32'h33);
    check_val("stream_stall", 32'(ifa.StallCnt), 32'd0);

    // Back-pressure into the skid entry
    ifa.ReadyM = 0; ifa.ValidE = 1; ifa.ALUResultE = 32'hA;
    tick();
    check_val("bp_validM_A", 32'(ifa.ValidM), 32'd1);
    check_val("bp_alu_A",    ifa.ALUResultM, 32'hA);
    ifa.ALUResultE = 32'hB;
    tick();
    check_val("bp_readyE_full", 32'(ifa.ReadyE), 32'd0);
    check_val("bp_alu_still_A", ifa.ALUResultM, 32'hA);
    ifa.ALUResultE = 32'hC;
    repeat (2) tick();
    check_val("bp_stall3", 32'(ifa.StallCnt), 32'd3);
    check_val("bp_hold_A", ifa.ALUResultM, 32'hA);
    ifa.ValidE = 0; ifa.ReadyM = 1;
    tick();
    check_val("bp_alu_B",    ifa.ALUResultM, 32'hB);
    check_val("bp_validM_B", 32'(ifa.ValidM), 32'd1);
    check_val("bp_readyE_1", 32'(ifa.ReadyE), 32'd1);
    tick();
    check_val("bp_empty_noC", 32'(ifa.ValidM), 32'd0);
    check_val("bp_stall_kept", 32'(ifa.StallCnt), 32'd3);

    // Flush while presenting a new entry in ONE
    ifa.ReadyM = 0; ifa.ValidE = 1; ifa.RegWriteE = 0; ifa.ALUResultE = 32'h55;
    tick();
    check_val("fl_validM_pre", 32'(ifa.ValidM), 32'd1);
    ifa.ALUResultE = 32'h66; ifa.MemWriteE = 1; ifa.FlushE = 1;
    tick();
    check_val("fl_validM",   32'(ifa.ValidM), 32'd0);
    check_val("fl_memwrite", 32'(ifa.MemWriteM), 32'd0);
    check_val("fl_readyE",   32'(ifa.ReadyE), 32'd1);
    check_val("fl_alu_kept", ifa.ALUResultM, 32'h55);
    check_val("fl_stall4",   32'(ifa.StallCnt), 32'd4);
    ifa.FlushE = 0; ifa.ValidE = 0; ifa.MemWriteE = 0; ifa.ReadyM = 1;
    tick();
    check_val("fl_never_out", 32'(ifa.ValidM), 32'd0);
    check_val("fl_alu_still", ifa.ALUResultM, 32'h55);

    // Fill to FULL then reset asynchronously between edges
    ifa.ReadyM = 0; ifa.ValidE = 1;
    ifa.PCSrcE = 1; ifa.RegWriteE = 1; ifa.MemtoRegE = 1; ifa.MemWriteE = 1;
    ifa.ALUResultE = 32'h91;
    tick();
    ifa.ALUResultE = 32'h92;
    tick();
    check_val("full_readyE", 32'(ifa.ReadyE), 32'd0);
    check_val("full_ctrl", 32'({ifa.PCSrcM, ifa.RegWriteM, ifa.MemtoRegM, ifa.MemWriteM}), 32'hF);
    check_val("full_stall5", 32'(ifa.StallCnt), 32'd5);
    idle_a();
    #2 RST = 1;
    #1;
    check_val("arst_validM", 32'(ifa.ValidM), 32'd0);
    check_val("arst_ctrl", 32'({ifa.PCSrcM, ifa.RegWriteM, ifa.MemtoRegM, ifa.MemWriteM}), 32'd0);
    check_val("arst_stall",  32'(ifa.StallCnt), 32'd0);
    check_val("arst_bubble", 32'(ifa.BubbleCnt), 32'd0);
    check_val("arst_readyE", 32'(ifa.ReadyE), 32'd1);
    check_val("arst_alu",    ifa.ALUResultM, 32'd0);
    #1 RST = 0;

    // Bubble counter saturation and clear
    ifa.ReadyM = 1;
    repeat (20) tick();
    check_val("sat_bubble15", 32'(ifa.BubbleCnt), 32'd15);
    tick();
    check_val("sat_hold15", 32'(ifa.BubbleCnt), 32'd15);
    ifa.CntClr = 1;
    tick();
    check_val("clr_bubble0", 32'(ifa.BubbleCnt), 32'd0);
    ifa.CntClr = 0;
    tick();
    check_val("clr_resume1", 32'(ifa.BubbleCnt), 32'd1);

    // Combinational ready without skid
    ifb.ReadyM = 0; ifb.ValidE = 1; ifb.ALUResultE = 32'h77;
    tick();
    ifb.ValidE = 0;
    #1;
    check_val("ns_validM", 32'(ifb.ValidM), 32'd1);
    check_val("ns_alu_P",  ifb.ALUResultM, 32'h77);
    check_val("ns_readyE_0", 32'(ifb.ReadyE), 32'd0);
    ifb.ReadyM = 1;
    #1;
    check_val("ns_readyE_follow1", 32'(ifb.ReadyE), 32'd1);
    ifb.ReadyM = 0;
    #1;
    check_val("ns_readyE_follow0", 32'(ifb.ReadyE), 32'd0);
    ifb.ReadyM = 1; ifb.ValidE = 1; ifb.ALUResultE = 32'h88;
    tick();
    check_val("ns_swap_validM", 32'(ifb.ValidM), 32'd1);
    check_val("ns_swap_alu_Q",  ifb.ALUResultM, 32'h88);
    ifb.ValidE = 0;
    tick();
    check_val("ns_drain_validM", 32'(ifb.ValidM), 32'd0);
    check_val("ns_drain_alu",    ifb.ALUResultM, 32'h88);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_reg_em_hs.md
Name: pipe_reg_em_hs

Overview:
- Parametrised Execute→Memory pipeline stage register with a valid/ready handshake, flush, and an optional one-entry skid buffer.
- Provides full throughput under back-pressure.
- Forces Memory-stage control outputs to 0 whenever the stage holds no valid instruction.
- Provides saturating stall and bubble performance counters.
- Sits between the conditional-execute logic and the data-memory stage of the pipelined core.

Parameters:
DATA_W, 32, width of ALUResult and WriteData
WA_W, 4, width of write-address (register index)
CNT_W, 16, width of each performance counter
SKID, 1, 1 = two-entry (main + skid) buffer with registered ReadyE; 0 = single register with combinational ReadyE

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous, active-high reset
ValidE  in  1  Execute stage presents an instruction
ReadyE  out  1  stage can accept this cycle
FlushE  in  1  synchronous kill of all stage contents
PCSrcE  in  1  conditioned PC-source control
RegWriteE  in  1  conditioned register-write control
MemtoRegE  in  1  conditioned mem-to-reg control
MemWriteE  in  1  conditioned memory-write control
ALUResultE  in  DATA_W  ALU result
WriteDataE  in  DATA_W  store data
WA3E  in  WA_W  destination register
ValidM  out  1  output entry valid
ReadyM  in  1  Memory stage accepts
PCSrcM  out  1  PCSrc control, gated by ValidM
RegWriteM  out  1  RegWrite control, gated by ValidM
MemtoRegM  out  1  MemtoReg control, gated by ValidM
MemWriteM  out  1  MemWrite control, gated by ValidM
ALUResultM  out  DATA_W  ALU result of output entry
WriteDataM  out  DATA_W  store data of output entry
WA3M  out  WA_W  destination register of output entry
CntClr  in  1  synchronous clear of both counters
StallCnt  out  CNT_W  cycles with ValidM=1 and ReadyM=0
BubbleCnt  out  CNT_W  cycles with ValidM=0 and ReadyM=1

Behaviour:
- Transfer definitions:
  - Input transfer (IN) = ValidE & ReadyE.
  - Output transfer (OUT) = ValidM & ReadyM.
- Reset (RST=1, asynchronous, any time including mid-transfer):
  - State returns to EMPTY.
  - Main and skid entries are invalidated; main and skid payload registers clear to 0.
  - All outputs are 0; counters are 0.
  - ReadyE is 1 after reset.
- States (SKID=1): EMPTY (main invalid), ONE (main valid, skid empty), FULL (main and skid valid).
  - ReadyE = (state != FULL), registered.
  - EMPTY: IN → ONE, main loaded.
  - ONE: IN&OUT → ONE, main loaded with new entry. IN&~OUT → FULL, skid loaded. ~IN&OUT → EMPTY. Otherwise hold.
  - FULL: OUT → ONE, main loaded from skid. Otherwise hold. ValidE is ignored.
- SKID=0: only EMPTY and ONE exist.
  - ReadyE = ~ValidM | ReadyM (combinational path from ReadyM).
  - IN loads main; OUT without IN → EMPTY.
- Latency and ordering:
  - Input to output latency is 1 cycle when the stage is empty: ValidM rises the cycle after IN.
  - FIFO order is preserved; no entry is duplicated or dropped except by FlushE or RST.
- Output gating:
  - PCSrcM, RegWriteM, MemtoRegM and MemWriteM each equal their stored bit AND ValidM.
  - ALUResultM, WriteDataM and WA3M hold their last loaded value while invalid. No data register loads without IN or a skid→main move.
- FlushE (priority over all handshake activity):
  - Next state is EMPTY.
  - An IN in the same cycle is dropped.
  - An OUT in the same cycle completes normally; the downstream stage owns it.
  - Payload registers are unchanged. ReadyE=1 the following cycle.
- Counters:
  - Each counter saturates at 2^CNT_W-1.
  - CntClr has priority over increment: the counter is 0 the next cycle.
  - Counters are unaffected by FlushE.

Decomposition:
- Shared package em_pkg:
  - em_ctrl_t: packed struct {pcsrc, regwrite, memtoreg, memwrite}.
  - em_payload_t: ctrl, alu_result, write_data, wa3; parametrised widths via package constants DATA_W_DEF=32, WA_W_DEF=4.
  - em_state_t: enum EMPTY=2'b00, ONE=2'b01, FULL=2'b10.
- Sub-module sat_counter (parameter CNT_W; ports inc, clr, count), instantiated twice.

Test Plan:
1. Reset mid-FULL:
   - Stimulus: assert RST asynchronously between edges.
   - Response: ValidM, all control outputs, StallCnt and BubbleCnt are 0 immediately; ReadyE=1.
2. Streaming (SKID=1, ReadyM=1):
   - Stimulus: ALUResultE 0x11, 0x22, 0x33 on consecutive cycles with RegWriteE=1.
   - Response: ALUResultM shows 0x11, 0x22, 0x33 one cycle later each; ReadyE stays 1; StallCnt=0.
3. Back-pressure (SKID=1):
   - Stimulus: ReadyM=0; send A=0xA then B=0xB; hold ReadyM=0 for 3 cycles, then set ReadyM=1.
   - Response: ValidM=1 showing A; ReadyE=0 after B; then A, then B on successive cycles; StallCnt=3.
4. Flush with simultaneous IN in ONE state:
   - Stimulus: MemWriteE=1 entry presented together with FlushE.
   - Response: next cycle ValidM=0, MemWriteM=0, ReadyE=1; the flushed word never appears.
5. Counter saturation and clear (CNT_W=4):
   - Stimulus: ReadyM=1, ValidE=0 for 20 cycles.
   - Response: BubbleCnt=15 and holds. Assert CntClr → BubbleCnt=0 next cycle, then resumes at 1.
6. SKID=0 combinational ready:
   - Stimulus: stage holds an entry; toggle ReadyM 0→1 within one cycle.
   - Response: ReadyE follows ReadyM combinationally; a new entry loads on the same edge that the old one transfers.
